obc_heartbeat_tx: RTL and testbench



---
 rtl/obc_heartbeat_tx.sv | 157 +++++++++++++++
 tb/tb_obc_heartbeat_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/obc_heartbeat_tx.sv
// Guardian heartbeat source: toggles only while flight software kicks inside its window.
// Guardian reset is seen through a 2-FF synchronizer plus one edge; status outputs change with the state.
module obc_heartbeat_tx #(
    parameter int CLOCK_FREQ_HZ          = 50_000_000,
    parameter int TOGGLE_PERIOD_CYCLES   = CLOCK_FREQ_HZ / 2,
    parameter int STARTUP_HOLDOFF_CYCLES = CLOCK_FREQ_HZ,
    parameter int KICK_WINDOW_MIN_CYCLES = CLOCK_FREQ_HZ / 10,
    parameter int KICK_TIMEOUT_CYCLES    = CLOCK_FREQ_HZ * 2,
    parameter int RESET_CNT_WIDTH        = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sw_kick_in,
    input  logic                       guardian_reset_in,
    output logic                       obc_heartbeat_out,
    output logic                       hb_active_out,
    output logic                       kick_fault_out,
    output logic [RESET_CNT_WIDTH-1:0] reset_count_out
);

    localparam logic [31:0] LP_TOGGLE_LAST  = 32'(TOGGLE_PERIOD_CYCLES - 1);
    localparam logic [31:0] LP_HOLDOFF_LAST = 32'(STARTUP_HOLDOFF_CYCLES - 1);
    localparam logic [31:0] LP_WIN_MIN      = 32'(KICK_WINDOW_MIN_CYCLES);
    localparam logic [31:0] LP_TIMEOUT_LAST = 32'(KICK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLDOFF  = 2'd0,
        ST_RUN      = 2'd1,
        ST_FAULT    = 2'd2,
        ST_IN_RESET = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_grst_meta;
    logic r_grst_sync;
    logic r_grst_prev;

    logic [31:0] r_toggle_tmr;
    logic [31:0] r_kick_tmr;
    logic [31:0] r_holdoff_tmr;

    logic                       r_hb;
    logic                       r_hb_active;
    logic                       r_kick_fault;
    logic [RESET_CNT_WIDTH-1:0] r_reset_cnt;

    logic w_grst_rise;
    logic w_toggle_hit;
    logic w_kick_ok;
    logic w_kick_early;
    logic w_kick_timeout;
    logic w_holdoff_done;
    logic w_stay_run;
    logic w_stay_holdoff;

    assign w_grst_rise    = r_grst_sync & ~r_grst_prev;
    assign w_toggle_hit   = (r_toggle_tmr == LP_TOGGLE_LAST);
    assign w_kick_ok      = sw_kick_in && (r_kick_tmr >= LP_WIN_MIN);
    assign w_kick_early   = sw_kick_in && (r_kick_tmr < LP_WIN_MIN);
    assign w_kick_timeout = !sw_kick_in && (r_kick_tmr == LP_TIMEOUT_LAST);
    assign w_holdoff_done = (r_holdoff_tmr == LP_HOLDOFF_LAST);
    assign w_stay_run     = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
    assign w_stay_holdoff = (r_state == ST_HOLDOFF) && (w_state_nxt == ST_HOLDOFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HOLDOFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Guardian edge outranks every kick/timeout decision in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_grst_rise) begin
            w_state_nxt = ST_IN_RESET;
        end else begin
            case (r_state)
                ST_HOLDOFF: begin
                    if (w_holdoff_done) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_kick_early || w_kick_timeout) w_state_nxt = ST_FAULT;
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                ST_IN_RESET: begin
                    if (!r_grst_sync) w_state_nxt = ST_HOLDOFF;
                end
                default: begin
                    w_state_nxt = ST_HOLDOFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grst_meta <= 1'b0;
            r_grst_sync <= 1'b0;
            r_grst_prev <= 1'b0;
        end else begin
            r_grst_meta <= guardian_reset_in;
            r_grst_sync <= r_grst_meta;
            r_grst_prev <= r_grst_sync;
        end
    end

    // Timers run only while the state persists, so every entry starts them from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_holdoff_tmr <= 32'd0;
            r_toggle_tmr  <= 32'd0;
            r_kick_tmr    <= 32'd0;
        end else begin
            r_holdoff_tmr <= w_stay_holdoff ? (r_holdoff_tmr + 32'd1) : 32'd0;
            if (w_stay_run) begin
                r_toggle_tmr <= w_toggle_hit ? 32'd0 : (r_toggle_tmr + 32'd1);
                r_kick_tmr   <= w_kick_ok ? 32'd0 : (r_kick_tmr + 32'd1);
            end else begin
                r_toggle_tmr <= 32'd0;
                r_kick_tmr   <= 32'd0;
            end
        end
    end

    // A fault edge freezes the heartbeat even if it coincides with a toggle point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hb         <= 1'b0;
            r_hb_active  <= 1'b0;
            r_kick_fault <= 1'b0;
            r_reset_cnt  <= '0;
        end else begin
            if (w_state_nxt == ST_IN_RESET) begin
                r_hb <= 1'b0;
            end else if (w_stay_run && w_toggle_hit) begin
                r_hb <= ~r_hb;
            end
            r_hb_active  <= (w_state_nxt == ST_RUN);
            r_kick_fault <= (w_state_nxt == ST_FAULT);
            if (w_grst_rise && (r_reset_cnt != '1)) begin
                r_reset_cnt <= r_reset_cnt + RESET_CNT_WIDTH'(1);
            end
        end
    end

    assign obc_heartbeat_out = r_hb;
    assign hb_active_out     = r_hb_active;
    assign kick_fault_out    = r_kick_fault;
    assign reset_count_out   = r_reset_cnt;

endmodule

// File: tb/tb_obc_heartbeat_tx.sv
// Bench for obc_heartbeat_tx: directed scenarios plus random kicks/guardian pulses/resets,
// all checked every cycle against a timestamp-based reference model.
module tb_obc_heartbeat_tx;

    localparam int TOG  = 4;
    localparam int HOLD = 8;
    localparam int WIN  = 3;
    localparam int TO   = 20;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_HOLD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;
    localparam int M_INRST = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sw_kick_in = 1'b0;
    logic          guardian_reset_in = 1'b0;
    logic          obc_heartbeat_out;
    logic          hb_active_out;
    logic          kick_fault_out;
    logic [CW-1:0] reset_count_out;

    obc_heartbeat_tx #(
        .CLOCK_FREQ_HZ         (8),
        .TOGGLE_PERIOD_CYCLES  (TOG),
        .STARTUP_HOLDOFF_CYCLES(HOLD),
        .KICK_WINDOW_MIN_CYCLES(WIN),
        .KICK_TIMEOUT_CYCLES   (TO),
        .RESET_CNT_WIDTH       (CW)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .sw_kick_in       (sw_kick_in),
        .guardian_reset_in(guardian_reset_in),
        .obc_heartbeat_out(obc_heartbeat_out),
        .hb_active_out    (hb_active_out),
        .kick_fault_out   (kick_fault_out),
        .reset_count_out  (reset_count_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode plus timestamps (edge indices) of mode entry and last accepted kick.
    int cyc     = 0;
    int m_mode  = M_HOLD;
    int t_enter = 0;
    int t_kick  = 0;
    int m_cnt   = 0;
    bit m_hb    = 1'b0;
    bit hb_base = 1'b0;
    bit g_a = 1'b0, g_b = 1'b0, g_c = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        check_eq("heartbeat", 32'(obc_heartbeat_out), 32'(m_hb));
        check_eq("hb_active", 32'(hb_active_out), (m_mode == M_RUN) ? 32'd1 : 32'd0);
        check_eq("kick_fault", 32'(kick_fault_out), (m_mode == M_FAULT) ? 32'd1 : 32'd0);
        check_eq("reset_count", 32'(reset_count_out), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_mode  = M_HOLD;
        t_enter = cyc;
        t_kick  = cyc;
        m_cnt   = 0;
        m_hb    = 1'b0;
        hb_base = 1'b0;
        g_a = 1'b0; g_b = 1'b0; g_c = 1'b0;
    endtask

    task automatic model_step(input bit k, input bit x);
        bit rise, lvl;
        int age;
        cyc++;
        rise = g_b & ~g_c;
        lvl  = g_b;
        g_c = g_b; g_b = g_a; g_a = x;
        if (rise) begin
            m_mode  = M_INRST;
            t_enter = cyc;
            m_hb    = 1'b0;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            case (m_mode)
                M_HOLD: if (cyc - t_enter == HOLD) begin
                    m_mode = M_RUN; t_enter = cyc; t_kick = cyc; hb_base = m_hb;
                end
                M_RUN: begin
                    age = cyc - 1 - t_kick;
                    if (k && age >= WIN) t_kick = cyc;
                    else if (k || age == TO - 1) m_mode = M_FAULT;
                    if (m_mode == M_RUN) m_hb = hb_base ^ bit'(((cyc - t_enter) / TOG) % 2);
                end
                M_INRST: if (!lvl) begin
                    m_mode = M_HOLD; t_enter = cyc;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input bit k, input bit x);
        sw_kick_in        = k;
        guardian_reset_in = x;
        @(posedge clk);
        model_step(k, x);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        sw_kick_in        = 1'b0;
        guardian_reset_in = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("reset_hb_zero", 32'(obc_heartbeat_out), 32'd0);
        check_eq("reset_cnt_zero", 32'(reset_count_out), 32'd0);
        @(posedge clk);
        cyc++;
        t_enter = cyc;
        t_kick  = cyc;
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic gpulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int g_left;
        int e_tgt;
        int t_run;
        int n;
        bit k;

        #3;
        do_reset();

        // Kick every 10 cycles: static for the hold-off, then a free-running square wave.
        for (int i = 0; i < 60; i++) tick(i % 10 == 4, 1'b0);
        check_eq("run_active", 32'(hb_active_out), 32'd1);
        check_eq("run_nofault", 32'(kick_fault_out), 32'd0);

        // Starve the kicks until timeout.
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);
        check_eq("timeout_fault", 32'(kick_fault_out), 32'd1);
        check_eq("timeout_inactive", 32'(hb_active_out), 32'd0);

        // Guardian reset out of FAULT, then hold-off and back to RUN.
        gpulse(6, 14);
        check_eq("recover_active", 32'(hb_active_out), 32'd1);
        check_eq("recover_cnt", 32'(reset_count_out), 32'd1);

        // Early second kick (timer 2) faults.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("early_fault", 32'(kick_fault_out), 32'd1);

        // Second kick exactly at the window minimum is accepted.
        gpulse(4, 14);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("window_ok_nofault", 32'(kick_fault_out), 32'd0);
        check_eq("window_ok_active", 32'(hb_active_out), 32'd1);

        // Count saturation, then a reset clears everything including the count.
        for (int p = 0; p < 5; p++) gpulse(4, 4);
        check_eq("cnt_saturated", 32'(reset_count_out), 32'(CMAX));
        do_reset();

        // Guardian edge, valid kick and toggle point all land on the same edge.
        for (int i = 0; i < HOLD; i++) tick(1'b0, 1'b0);
        t_run = t_enter;
        e_tgt = t_run + 3 * TOG;
        while (cyc < e_tgt) begin
            n = cyc + 1;
            tick((n == t_run + 5) || (n == e_tgt), n >= e_tgt - 2);
        end
        check_eq("coinc_hb_zero", 32'(obc_heartbeat_out), 32'd0);
        check_eq("coinc_nofault", 32'(kick_fault_out), 32'd0);
        check_eq("coinc_inactive", 32'(hb_active_out), 32'd0);
        check_eq("coinc_cnt", 32'(reset_count_out), 32'd1);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

        // Random kicks, guardian pulses of random length, and rare resets.
        g_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                g_left = 0;
            end else begin
                k = ($urandom_range(0, 7) == 0);
                if (g_left > 0) begin
                    g_left--;
                    tick(k, 1'b1);
                end else if ($urandom_range(0, 149) == 0) begin
                    g_left = $urandom_range(0, 7);
                    tick(k, 1'b1);
                end else begin
                    tick(k, 1'b0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
